alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_muldiv_iter.sv | 67 ++++++
 rtl/alu_seq.sv | 131 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and sequencer state encoding.
package alu_pkg;

    typedef logic [3:0] aluop_t;

    localparam aluop_t OpAnd  = 4'b0000;
    localparam aluop_t OpOr   = 4'b0001;
    localparam aluop_t OpAdd  = 4'b0010;
    localparam aluop_t OpSub  = 4'b0110;
    localparam aluop_t OpSlt  = 4'b0111;
    localparam aluop_t OpMul  = 4'b1000;
    localparam aluop_t OpDivu = 4'b1001;
    localparam aluop_t OpRemu = 4'b1010;
    localparam aluop_t OpNor  = 4'b1100;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between an ALU client (master) and alu_seq (slave).
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    aluop_t           ALUOp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             zero;
    logic             less;
    logic             CarryOut;

    modport master (
        output in_valid, a, b, ALUOp, out_ready,
        input  in_ready, out_valid, Result, zero, less, CarryOut
    );

    modport slave (
        input  in_valid, a, b, ALUOp, out_ready,
        output in_ready, out_valid, Result, zero, less, CarryOut
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// last_o flags the cycle whose step completes the operation; acc_o/quo_o show that step's values.
module alu_muldiv_iter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    // r: product accumulator / partial remainder; p: multiplicand / dividend->quotient;
    // d: multiplier / divisor.
    always_comb begin
        rem_shift = {r_q, p_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, d_q};
        rem_sub   = rem_shift[WIDTH-1:0] - d_q;
        if (is_div_q) begin
            r_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
            p_d = {p_q[WIDTH-2:0], rem_ge};
            d_d = d_q;
        end else begin
            r_d = d_q[0] ? r_q + p_q : r_q;
            p_d = p_q << 1;
            d_d = d_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            r_q      <= '0;
            p_q      <= '0;
            d_q      <= '0;
        end else if (start_i) begin
            cnt_q    <= CNT_W'(WIDTH);
            is_div_q <= is_div_i;
            r_q      <= '0;
            p_q      <= a_i;
            d_q      <= b_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            r_q   <= r_d;
            p_q   <= p_d;
            d_q   <= d_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));
    assign acc_o  = r_d;
    assign quo_o  = p_d;
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative MUL/DIVU/REMU, valid/ready on both sides.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    aluop_t           op_q;
    logic [WIDTH-1:0] result_q, res_d;
    logic             zero_q;
    logic             carry_q, carry_d;
    logic             accept, load, start, iter_op;
    logic             iter_last;
    logic [WIDTH-1:0] iter_acc, iter_quo;
    logic [WIDTH-1:0] fast_res;
    logic             fast_carry;
    logic [WIDTH:0]   add_full, sub_full;
    logic             less_in;

    // Subtraction as a + ~b + 1 so the carry bit is the no-borrow flag.
    always_comb begin
        add_full   = {1'b0, bus.a} + {1'b0, bus.b};
        sub_full   = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH + 1)'(1);
        less_in    = $signed(bus.a) < $signed(bus.b);
        fast_res   = '0;
        fast_carry = 1'b0;
        case (bus.ALUOp)
            OpAnd: fast_res = bus.a & bus.b;
            OpOr:  fast_res = bus.a | bus.b;
            OpNor: fast_res = ~(bus.a | bus.b);
            OpAdd: {fast_carry, fast_res} = add_full;
            OpSub: {fast_carry, fast_res} = sub_full;
            OpSlt: fast_res = {{(WIDTH - 1){1'b0}}, less_in};
            OpDivu: fast_res = '1;
            OpRemu: fast_res = bus.a;
            default: fast_res = '0;
        endcase
    end

    // Division by zero bypasses the iterator and completes through the fast path.
    assign iter_op = (bus.ALUOp == OpMul) ||
                     (((bus.ALUOp == OpDivu) || (bus.ALUOp == OpRemu)) && (bus.b != '0));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        load    = 1'b0;
        start   = 1'b0;
        res_d   = '0;
        carry_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (iter_op) begin
                        start   = 1'b1;
                        state_d = StBusy;
                    end else begin
                        load    = 1'b1;
                        res_d   = fast_res;
                        carry_d = fast_carry;
                        state_d = StDone;
                    end
                end
            end
            StBusy: begin
                if (iter_last) begin
                    load    = 1'b1;
                    res_d   = (op_q == OpDivu) ? iter_quo : iter_acc;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OpAnd;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q  <= bus.a;
                b_q  <= bus.b;
                op_q <= bus.ALUOp;
            end
            if (load) begin
                result_q <= res_d;
                zero_q   <= (res_d == '0);
                carry_q  <= carry_d;
            end
        end
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start),
        .is_div_i (bus.ALUOp != OpMul),
        .a_i      (bus.a),
        .b_i      (bus.b),
        .last_o   (iter_last),
        .acc_o    (iter_acc),
        .quo_o    (iter_quo)
    );

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.Result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.less      = $signed(a_q) < $signed(b_q);
    assign bus.CarryOut  = carry_q;
endmodule
